// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline hazard inputs and stall/flush strobes.
// Latency: none, plain wires grouped for port hygiene.
// Backpressure: stall/flush outputs are the backpressure toward PC and IF/ID.
interface hazard_ctrl_if;
    logic [2:0]  id_rx;
    logic [2:0]  id_ry;
    logic        id_use_rx;
    logic        id_use_ry;
    logic [1:0]  ex_mem_read;
    logic        ex_reg_write;
    logic [2:0]  ex_dst;
    logic        ex_branch_taken;
    logic        ex_jump;
    logic        mem_access;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic [1:0]  hz_state;
    logic [15:0] stall_count;

    // Pipeline side: drives hazard sources, observes enables/flushes
    modport master (
        output id_rx, id_ry, id_use_rx, id_use_ry, ex_mem_read, ex_reg_write,
               ex_dst, ex_branch_taken, ex_jump, mem_access,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
               hz_state, stall_count
    );

    // Hazard controller side
    modport slave (
        input  id_rx, id_ry, id_use_rx, id_use_ry, ex_mem_read, ex_reg_write,
               ex_dst, ex_branch_taken, ex_jump, mem_access,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
               hz_state, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 16-bit 5-stage pipeline: load-use, branch/jump flush, SRAM structural stall.
// Latency: outputs combinational from registered state + current inputs; multi-cycle hazards via down-counter.
// Backpressure: deasserts PC/IF-ID write enables and injects bubbles; HAZARD_PERF_CNT_EN adds a stall counter.
module hazard_ctrl #(
    parameter int LOAD_USE_BUBBLES    = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int MEM_WAIT_CYCLES     = 1,
    parameter int CNT_W               = 4
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_if.slave hz_bus
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic branch;
    logic src_match;
    logic lu_hit;
    logic lu_stall;
    logic mem_stall;
    logic pc_we, ifid_we, ifid_fl, idex_fl;

    // Hazard detection and stall/flush strobes; branch wins, then SRAM conflict, then load-use
    always_comb begin
        branch    = hz_bus.ex_branch_taken | hz_bus.ex_jump;
        src_match = (hz_bus.id_use_rx & (hz_bus.id_rx == hz_bus.ex_dst)) |
                    (hz_bus.id_use_ry & (hz_bus.id_ry == hz_bus.ex_dst));
        // EX holds a bubble during LOAD_STALL, so its fields are stale and ignored
        lu_hit    = (state_q != LOAD_STALL) & (hz_bus.ex_mem_read != 2'b00) &
                    hz_bus.ex_reg_write & src_match;
        lu_stall  = lu_hit | (state_q == LOAD_STALL);
        mem_stall = hz_bus.mem_access | (state_q == MEM_WAIT);
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        ifid_fl = 1'b0;
        idex_fl = 1'b0;
        if (RST) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
        end else if (branch || state_q == FLUSH) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
        end else if (mem_stall && lu_stall) begin
            // ID instruction held in IF/ID, so the fetch slot need not be squashed
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
        end else if (mem_stall) begin
            pc_we   = 1'b0;
            ifid_fl = 1'b1;
        end else if (lu_stall) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
        end
    end

    // Next state / counter; a counter at 0 or 1 always returns to RUN so it cannot underflow
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (branch) begin
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_d = FLUSH;
                cnt_d   = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
            end else begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                FLUSH, LOAD_STALL: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (lu_hit && LOAD_USE_BUBBLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CNT_W'(LOAD_USE_BUBBLES - 1);
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (lu_hit && LOAD_USE_BUBBLES > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CNT_W'(LOAD_USE_BUBBLES - 1);
                    end else if (hz_bus.mem_access && MEM_WAIT_CYCLES > 1) begin
                        state_d = MEM_WAIT;
                        cnt_d   = CNT_W'(MEM_WAIT_CYCLES - 1);
                    end
                end
            endcase
        end
    end

    // FSM state and counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz_bus.pc_write_en    = pc_we;
    assign hz_bus.if_id_write_en = ifid_we;
    assign hz_bus.if_id_flush    = ifid_fl;
    assign hz_bus.id_ex_flush    = idex_fl;
    assign hz_bus.hz_state       = RST ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles with the PC frozen
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= 16'h0000;
        end else if (!pc_we && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign hz_bus.stall_count = stall_cnt_q;
`else
    assign hz_bus.stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with two parameterisations.
// A: LOAD_USE_BUBBLES=1, BRANCH_FLUSH_CYCLES=2, MEM_WAIT_CYCLES=1.
// B: LOAD_USE_BUBBLES=3, BRANCH_FLUSH_CYCLES=1, MEM_WAIT_CYCLES=2.
module tb_hazard_ctrl;
    logic CLK = 1'b0;
    logic RST;

    logic [2:0] id_rx, id_ry, ex_dst;
    logic       id_use_rx, id_use_ry, ex_reg_write, ex_branch_taken, ex_jump, mem_access;
    logic [1:0] ex_mem_read;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    hazard_ctrl_if if_a();
    hazard_ctrl_if if_b();

    assign if_a.id_rx = id_rx;                 assign if_b.id_rx = id_rx;
    assign if_a.id_ry = id_ry;                 assign if_b.id_ry = id_ry;
    assign if_a.id_use_rx = id_use_rx;         assign if_b.id_use_rx = id_use_rx;
    assign if_a.id_use_ry = id_use_ry;         assign if_b.id_use_ry = id_use_ry;
    assign if_a.ex_mem_read = ex_mem_read;     assign if_b.ex_mem_read = ex_mem_read;
    assign if_a.ex_reg_write = ex_reg_write;   assign if_b.ex_reg_write = ex_reg_write;
    assign if_a.ex_dst = ex_dst;               assign if_b.ex_dst = ex_dst;
    assign if_a.ex_branch_taken = ex_branch_taken; assign if_b.ex_branch_taken = ex_branch_taken;
    assign if_a.ex_jump = ex_jump;             assign if_b.ex_jump = ex_jump;
    assign if_a.mem_access = mem_access;       assign if_b.mem_access = mem_access;

    hazard_ctrl #(.LOAD_USE_BUBBLES(1), .BRANCH_FLUSH_CYCLES(2), .MEM_WAIT_CYCLES(1), .CNT_W(4))
        dut_a (.CLK(CLK), .RST(RST), .hz_bus(if_a));
    hazard_ctrl #(.LOAD_USE_BUBBLES(3), .BRANCH_FLUSH_CYCLES(1), .MEM_WAIT_CYCLES(2), .CNT_W(4))
        dut_b (.CLK(CLK), .RST(RST), .hz_bus(if_b));

    // {pc_write_en, if_id_write_en, if_id_flush, id_ex_flush, hz_state}
    logic [5:0] obs_a, obs_b;
    assign obs_a = {if_a.pc_write_en, if_a.if_id_write_en, if_a.if_id_flush, if_a.id_ex_flush, if_a.hz_state};
    assign obs_b = {if_b.pc_write_en, if_b.if_id_write_en, if_b.if_id_flush, if_b.id_ex_flush, if_b.hz_state};

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        id_rx = 3'd0; id_ry = 3'd0; id_use_rx = 1'b0; id_use_ry = 1'b0;
        ex_mem_read = 2'b00; ex_reg_write = 1'b0; ex_dst = 3'd0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0; mem_access = 1'b0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 2'b01; ex_reg_write = 1'b1; ex_dst = 3'd3;
        id_rx = 3'd3; id_use_rx = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== 6'b001100) $display("FAIL reset_a cyc%0d got %b exp %b", i, obs_a, 6'b001100);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== 6'b001100) $display("FAIL reset_b cyc%0d got %b exp %b", i, obs_b, 6'b001100);
            else pass_cnt++;
            @(posedge CLK); #1;
        end
        RST = 1'b0;
        @(negedge CLK);
        chk_cnt++;
        if (obs_a !== 6'b110000) $display("FAIL post_reset_a got %b exp %b", obs_a, 6'b110000);
        else pass_cnt++;
        chk_cnt++;
        if (obs_b !== 6'b110000) $display("FAIL post_reset_b got %b exp %b", obs_b, 6'b110000);
        else pass_cnt++;
        @(posedge CLK); #1;
    endtask

    // Load-use in the first cycle only; EX holds a bubble afterwards
    task automatic test_load_use();
        logic [5:0] exp_a [4] = '{6'b000100, 6'b110000, 6'b110000, 6'b110000};
        logic [5:0] exp_b [4] = '{6'b000100, 6'b000101, 6'b000101, 6'b110000};
        set_load_use();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== exp_a[i]) $display("FAIL load_use_a cyc%0d got %b exp %b", i, obs_a, exp_a[i]);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL load_use_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    // Near misses: source not read, no regWrite, not a load, different register
    task automatic test_no_stall();
        for (int p = 0; p < 4; p++) begin
            set_load_use();
            case (p)
                0: id_use_rx = 1'b0;
                1: ex_reg_write = 1'b0;
                2: ex_mem_read = 2'b00;
                default: id_rx = 3'd4;
            endcase
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== 6'b110000) $display("FAIL no_stall_a pat%0d got %b exp %b", p, obs_a, 6'b110000);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== 6'b110000) $display("FAIL no_stall_b pat%0d got %b exp %b", p, obs_b, 6'b110000);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    // Load into r0 through the ry port, memRead=2'b10
    task automatic test_r0();
        logic [5:0] exp_b [4] = '{6'b000100, 6'b000101, 6'b000101, 6'b110000};
        ex_mem_read = 2'b10; ex_reg_write = 1'b1; ex_dst = 3'd0;
        id_ry = 3'd0; id_use_ry = 1'b1; id_rx = 3'd5; id_use_rx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (i == 0) begin
                chk_cnt++;
                if (obs_a !== 6'b000100) $display("FAIL r0_a got %b exp %b", obs_a, 6'b000100);
                else pass_cnt++;
            end
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL r0_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    // Branch taken in the middle of B's LOAD_STALL; A shows a 2-cycle flush
    task automatic test_branch_abort();
        logic [5:0] exp_a [5] = '{6'b000100, 6'b110000, 6'b111100, 6'b111110, 6'b110000};
        logic [5:0] exp_b [5] = '{6'b000100, 6'b000101, 6'b111101, 6'b110000, 6'b110000};
        set_load_use();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== exp_a[i]) $display("FAIL branch_a cyc%0d got %b exp %b", i, obs_a, exp_a[i]);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL branch_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
            if (i == 1) ex_branch_taken = 1'b1;
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0] exp_a [3] = '{6'b011000, 6'b110000, 6'b110000};
        logic [5:0] exp_b [3] = '{6'b011000, 6'b011011, 6'b110000};
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== exp_a[i]) $display("FAIL mem_a cyc%0d got %b exp %b", i, obs_a, exp_a[i]);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL mem_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    task automatic test_jump_vs_mem();
        logic [5:0] exp_a [3] = '{6'b111100, 6'b111110, 6'b110000};
        logic [5:0] exp_b [3] = '{6'b111100, 6'b110000, 6'b110000};
        mem_access = 1'b1; ex_jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== exp_a[i]) $display("FAIL jump_mem_a cyc%0d got %b exp %b", i, obs_a, exp_a[i]);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL jump_mem_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    task automatic test_mem_and_load_use();
        logic [5:0] exp_a [4] = '{6'b000100, 6'b110000, 6'b110000, 6'b110000};
        logic [5:0] exp_b [4] = '{6'b000100, 6'b000101, 6'b000101, 6'b110000};
        set_load_use();
        mem_access = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk_cnt++;
            if (obs_a !== exp_a[i]) $display("FAIL mem_lu_a cyc%0d got %b exp %b", i, obs_a, exp_a[i]);
            else pass_cnt++;
            chk_cnt++;
            if (obs_b !== exp_b[i]) $display("FAIL mem_lu_b cyc%0d got %b exp %b", i, obs_b, exp_b[i]);
            else pass_cnt++;
            @(posedge CLK); #1;
            clear_inputs();
        end
    endtask

    task automatic test_stall_count();
`ifdef HAZARD_PERF_CNT_EN
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk_cnt++;
        if (if_a.stall_count !== 16'h0000) $display("FAIL stall_cnt_clr got %h exp %h", if_a.stall_count, 16'h0000);
        else pass_cnt++;
        @(posedge CLK); #1;
        mem_access = 1'b1;
        repeat (5) begin
            @(posedge CLK); #1;
        end
        clear_inputs();
        @(negedge CLK);
        chk_cnt++;
        if (if_a.stall_count !== 16'd5) $display("FAIL stall_cnt5_a got %0d exp %0d", if_a.stall_count, 5);
        else pass_cnt++;
        chk_cnt++;
        if (if_b.stall_count !== 16'd5) $display("FAIL stall_cnt5_b got %0d exp %0d", if_b.stall_count, 5);
        else pass_cnt++;
        @(posedge CLK); #1;
        mem_access = 1'b1;
        repeat (70000) begin
            @(posedge CLK); #1;
        end
        clear_inputs();
        @(negedge CLK);
        chk_cnt++;
        if (if_a.stall_count !== 16'hFFFF) $display("FAIL stall_cnt_sat got %h exp %h", if_a.stall_count, 16'hFFFF);
        else pass_cnt++;
        @(posedge CLK); #1;
`else
        // Stalls have occurred by now, yet the disabled counter must read zero
        @(negedge CLK);
        chk_cnt++;
        if (if_a.stall_count !== 16'h0000) $display("FAIL stall_cnt_off_a got %h exp %h", if_a.stall_count, 16'h0000);
        else pass_cnt++;
        chk_cnt++;
        if (if_b.stall_count !== 16'h0000) $display("FAIL stall_cnt_off_b got %h exp %h", if_b.stall_count, 16'h0000);
        else pass_cnt++;
        @(posedge CLK); #1;
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_r0();
        test_branch_abort();
        test_mem_wait();
        test_jump_vs_mem();
        test_mem_and_load_use();
        test_stall_count();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
